score_loader: RTL and testbench

SCORE_LOADER -- requirements
Module: score_loader

---
 rtl/score_loader_pkg.sv | 21 ++
 rtl/score_result_encoder.sv | 32 +++
 rtl/score_loader.sv | 109 ++++++++++
 tb/tb_score_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/score_loader_pkg.sv
// Shared definitions for the score loader: frame geometry, FSM states and
// the bit layout of the result byte.
package score_loader_pkg;

   localparam int NUM_SCORES      = 5;
   localparam int BYTES_PER_SCORE = 4;
   localparam int FRAME_BYTES     = NUM_SCORES * BYTES_PER_SCORE;

   localparam int RES_IDX_LSB   = 0;
   localparam int RES_IDX_MSB   = 2;
   localparam int RES_MULTI_BIT = 6;
   localparam int RES_NOWIN_BIT = 7;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_FIRE   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESULT = 2'd3
   } state_e;

endpackage

// File: rtl/score_result_encoder.sv
// Maps the captured winner flags onto the result byte:
// single winner index, multi-winner flag or no-winner flag.
module score_result_encoder
   import score_loader_pkg::*;
(
   input  logic [NUM_SCORES-1:0] p_i,
   output logic [7:0]            res_o
);

   logic [2:0] hits;
   logic [2:0] idx;

   always_comb begin
      hits  = '0;
      idx   = '0;
      res_o = '0;
      for (int i = 0; i < NUM_SCORES; i++) begin
         if (p_i[i]) begin
            hits = hits + 3'd1;
            idx  = 3'(i + 1);
         end
      end
      if (hits == 3'd0) begin
         res_o[RES_NOWIN_BIT] = 1'b1;
      end else if (hits == 3'd1) begin
         res_o[RES_IDX_MSB:RES_IDX_LSB] = idx;
      end else begin
         res_o[RES_MULTI_BIT] = 1'b1;
      end
   end

endmodule

// File: rtl/score_loader.sv
// Assembles five little-endian 32-bit scores from a byte stream, strobes the
// external winner comparator, captures its flags and returns one result byte.
module score_loader #(
   parameter int NUM_SCORES      = score_loader_pkg::NUM_SCORES,
   parameter int BYTES_PER_SCORE = score_loader_pkg::BYTES_PER_SCORE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [31:0] x1,
   output logic [31:0] x2,
   output logic [31:0] x3,
   output logic [31:0] x4,
   output logic [31:0] x5,
   output logic        en,
   input  logic        p1,
   input  logic        p2,
   input  logic        p3,
   input  logic        p4,
   input  logic        p5,
   output logic        res_valid,
   output logic [7:0]  res_data,
   input  logic        res_ready
);

   import score_loader_pkg::*;

   state_e                state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [31:0]           x_q [NUM_SCORES];
   logic [NUM_SCORES-1:0] p_q;
   logic [7:0]            enc_res;
   logic                  accept;
   logic [2:0]            sel;
   logic [4:0]            lane_ofs;

   assign in_ready  = (state_q == ST_LOAD);
   assign en        = (state_q == ST_FIRE);
   assign res_valid = (state_q == ST_RESULT);
   // clr wins over a byte offered in the same cycle, so that byte is lost.
   assign accept    = in_valid && in_ready && !clr;
   assign sel       = cnt_q[4:2];
   assign lane_ofs  = {cnt_q[1:0], 3'b000};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  if (cnt_q == 5'(FRAME_BYTES - 1)) begin
                     cnt_d   = '0;
                     state_d = ST_FIRE;
                  end else begin
                     cnt_d = cnt_q + 5'd1;
                  end
               end
            end
            ST_FIRE:   state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_RESULT;
            ST_RESULT: if (res_ready) state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_WAIT) p_q <= {p5, p4, p3, p2, p1};
      end
   end

   // Scores are never cleared by clr; only reset wipes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SCORES; i++) x_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SCORES; i++) begin
            if (accept && sel == 3'(i)) x_q[i][lane_ofs +: 8] <= in_data;
         end
      end
   end

   score_result_encoder u_enc (
      .p_i   (p_q),
      .res_o (enc_res)
   );

   assign res_data = res_valid ? enc_res : 8'h00;
   assign x1 = x_q[0];
   assign x2 = x_q[1];
   assign x3 = x_q[2];
   assign x4 = x_q[3];
   assign x5 = x_q[4];

endmodule

// File: tb/tb_score_loader.sv
// Bench for score_loader: directed frame table, clr/rst corner sequences and
// random frames against a unique-maximum comparator and result model.
module tb_score_loader;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, res_ready;
   logic [7:0]  in_data;
   logic        in_ready, en, res_valid;
   logic [31:0] x1, x2, x3, x4, x5;
   logic [7:0]  res_data;
   logic [4:0]  p_model = '0;
   logic [4:0]  p_drv;
   logic        force_multi = 1'b0;

   int total = 0;
   int bad   = 0;

   typedef logic [4:0][31:0] frame_t;

   typedef struct {
      frame_t     sc;
      logic [7:0] exp;
      bit         fm;
      bit         cr;
      int         hold;
      int         gaps;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   score_loader dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5),
      .en(en),
      .p1(p_drv[0]), .p2(p_drv[1]), .p3(p_drv[2]), .p4(p_drv[3]), .p5(p_drv[4]),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
   );

   // Winner comparator: flags the score that is strictly greater than all others.
   function automatic logic [4:0] cmp_flags(input frame_t v);
      logic [31:0] mx;
      int          n;
      logic [4:0]  f;
      mx = v[0];
      for (int i = 1; i < 5; i++) if (v[i] > mx) mx = v[i];
      n = 0;
      f = '0;
      for (int i = 0; i < 5; i++) if (v[i] == mx) begin n++; f[i] = 1'b1; end
      return (n == 1) ? f : 5'b0;
   endfunction

   function automatic logic [7:0] model_res(input frame_t v);
      logic [4:0] f;
      f = cmp_flags(v);
      for (int i = 0; i < 5; i++) if (f[i]) return 8'(i + 1);
      return 8'h80;
   endfunction

   function automatic frame_t mk(input logic [31:0] a, b, c, d, e);
      frame_t r;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
      return r;
   endfunction

   always_ff @(posedge clk) if (en) p_model <= cmp_flags(mk(x1, x2, x3, x4, x5));
   assign p_drv = force_multi ? 5'b00101 : p_model;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_frame(input frame_t sc, input logic [7:0] exp, input bit fm,
                            input bit cr, input int hold, input int gaps);
      int         ens;
      logic [7:0] held;
      ens = 0;
      for (int k = 0; k < 20; k++) begin
         if (gaps > 0) begin
            int g;
            g = $urandom_range(0, gaps);
            in_valid = 1'b0;
            for (int j = 0; j < g; j++) begin
               tick();
               if (en) ens++;
            end
         end
         in_valid = 1'b1;
         in_data  = sc[k / 4][8 * (k % 4) +: 8];
         tick();
         if (en) ens++;
      end
      in_valid = 1'b0;
      check("en_after_byte19", {31'b0, en}, 32'd1);
      check("in_ready_fire", {31'b0, in_ready}, 32'd0);
      check("x1", x1, sc[0]);
      check("x2", x2, sc[1]);
      check("x3", x3, sc[2]);
      check("x4", x4, sc[3]);
      check("x5", x5, sc[4]);
      force_multi = fm;
      tick();
      if (en) ens++;
      tick();
      if (en) ens++;
      force_multi = 1'b0;
      check("res_valid", {31'b0, res_valid}, 32'd1);
      check("res_data", {24'b0, res_data}, {24'b0, exp});
      held = res_data;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (en) ens++;
         check("hold_valid", {31'b0, res_valid}, 32'd1);
         check("hold_data", {24'b0, res_data}, {24'b0, held});
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (cr) clr = 1'b1;
      else    res_ready = 1'b1;
      tick();
      clr = 1'b0;
      res_ready = 1'b0;
      check("en_pulses", 32'(ens), 32'd1);
      check("back_to_load", {31'b0, in_ready}, 32'd1);
      check("res_valid_off", {31'b0, res_valid}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t sc;
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;

      tbl[0] = '{mk(5, 9, 3, 1, 2),                8'h02, 1'b0, 1'b0, 0,  0};
      tbl[1] = '{mk(7, 7, 1, 1, 1),                8'h80, 1'b0, 1'b0, 0,  0};
      tbl[2] = '{mk(1, 2, 3, 4, 32'hFFFF_FFFF),    8'h05, 1'b0, 1'b0, 10, 0};
      tbl[3] = '{mk(3, 3, 3, 3, 3),                8'h40, 1'b1, 1'b0, 2,  0};
      tbl[4] = '{mk(0, 0, 32'h0100_0000, 0, 0),    8'h03, 1'b0, 1'b1, 3,  2};
      tbl[5] = '{mk(0, 0, 0, 32'h100, 32'hFF),     8'h04, 1'b0, 1'b0, 1,  3};
      tbl[6] = '{mk(32'h8000_0000, 5, 5, 5, 5),    8'h01, 1'b0, 1'b1, 0,  0};

      repeat (2) tick();
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_en", {31'b0, en}, 32'd0);
      check("rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("rst_res_data", {24'b0, res_data}, 32'd0);
      check("rst_x_or", x1 | x2 | x3 | x4 | x5, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++)
         run_frame(tbl[i].sc, tbl[i].exp, tbl[i].fm, tbl[i].cr, tbl[i].hold, tbl[i].gaps);

      // clr mid-frame: partial scores stay, the byte offered alongside clr is dropped.
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + k);
         tick();
      end
      clr = 1'b1;
      in_data = 8'hEE;
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      check("clr_en", {31'b0, en}, 32'd0);
      check("clr_in_ready", {31'b0, in_ready}, 32'd1);
      check("clr_keeps_x1", x1, 32'h1312_1110);
      check("clr_drops_byte", x3, 32'h0000_1918);
      tick();
      run_frame(mk(1, 2, 3, 4, 32'hFFFF_FFFF), 8'h05, 1'b0, 1'b0, 0, 0);

      // Asynchronous reset while byte 7 is on the bus.
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_data  = 8'hA5;
         tick();
      end
      in_data = 8'h5A;
      #3;
      rst = 1'b1;
      #1;
      check("arst_x1", x1, 32'd0);
      check("arst_x2", x2, 32'd0);
      check("arst_in_ready", {31'b0, in_ready}, 32'd1);
      check("arst_res_valid", {31'b0, res_valid}, 32'd0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      run_frame(mk(1, 0, 0, 0, 0), 8'h01, 1'b0, 1'b0, 0, 0);

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 5; i++)
            sc[i] = (r % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         run_frame(sc, model_res(sc), 1'b0, 1'b0, $urandom_range(0, 4), $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
